core_sequencer: RTL and testbench

- Multi-cycle control FSM for the single-issue RV32I core.
- Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU and register file.
- Arbitrates the single shared memory port between instruction fetch and load/store.
- Drives the PC, IR and register-file enables. Keeps a retired-instruction counter.

---
 rtl/core_sequencer.sv | 155 +++++++++++++++
 tb/tb_core_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core with a shared memory port.
// Define MEM_TIMEOUT_EN to add the memory-ack watchdog (HALT state and sticky fault).
module core_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        dec_mem,
    input  logic        dec_mem_read,
    input  logic        dec_branch,
    input  logic [1:0]  dec_wb,
    input  logic        branch_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        pc_load,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        busy,
    output logic        fault,
    output logic [31:0] instret,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic        taken_q, taken_d;
    logic [31:0] instret_q, instret_d;
    logic        timeout;

    // The PC register owns RESET_PC; it is carried here only so both blocks share one parameter set.
    logic unused_params;
    assign unused_params = ^{RESET_PC, TIMEOUT_CYCLES};

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] wait_q, wait_d;
    logic            fault_q, fault_d;
    logic            mem_wait;

    // Counter stays zero outside a stalled request, so every FETCH/MEM entry starts from zero.
    assign mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !mem_ack;
    assign timeout  = mem_wait && (wait_q == CntLast);
    assign wait_d   = mem_wait ? wait_q + 1'b1 : '0;
    assign fault_d  = fault_q | timeout;
    assign fault    = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign fault   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            taken_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            taken_q   <= taken_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        taken_d      = taken_q;
        instret_d    = instret_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_sel       = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StHalt;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (dec_branch) begin
                    if (branch_taken) begin
                        pc_load = 1'b1;
                        pc_sel  = 1'b1;
                        taken_d = 1'b1;
                    end
                    state_d = StWb;
                end else if (dec_mem) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = ~dec_mem_read;
                if (mem_ack) state_d = StWb;
                else if (timeout) state_d = StHalt;
            end
            StWb: begin
                rf_we     = dec_wb[1];
                wb_sel    = dec_wb[0];
                // A taken branch already redirected the PC in EXEC.
                pc_load   = ~taken_q;
                taken_d   = 1'b0;
                instret_d = instret_q + 32'd1;
                state_d   = run ? StFetch : StIdle;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle) && (state_q != StHalt);
    assign instret   = instret_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench: expected per-cycle traces are generated from instruction descriptions.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout path.
module tb_core_sequencer;

    logic        clk, rst_n, run, dec_mem, dec_mem_read, dec_branch, branch_taken, mem_ack;
    logic [1:0]  dec_wb;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel, rf_we, wb_sel;
    logic        busy, fault;
    logic [31:0] instret;
    logic [2:0]  state_dbg;

    core_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .dec_mem(dec_mem), .dec_mem_read(dec_mem_read),
        .dec_branch(dec_branch), .dec_wb(dec_wb), .branch_taken(branch_taken),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .busy(busy), .fault(fault), .instret(instret), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run, mem, rd, br, bt, ack;
        logic [1:0]  wb;
        logic [12:0] exp;
        logic [31:0] exp_instret;
    } cyc_t;

    cyc_t        q[$];
    int          n_chk = 0, n_fail = 0, n_cyc = 0;
    logic [31:0] m_instret = 0;
    logic        m_fault = 1'b0;
    logic        cur_mem, cur_rd, cur_br, cur_bt;
    logic [1:0]  cur_wb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_cyc(input logic [2:0] st, input logic ack, input logic req, we, asel,
                           irl, pcl, pcs, rfwe, wbs, input logic run_v);
        cyc_t c;
        logic bsy;
        bsy = (st != 3'd0) && (st != 3'd6);
        c.run = run_v; c.mem = cur_mem; c.rd = cur_rd; c.br = cur_br; c.bt = cur_bt;
        c.wb = cur_wb; c.ack = ack;
        c.exp = {st, req, we, asel, irl, pcl, pcs, rfwe, wbs, bsy, m_fault};
        c.exp_instret = m_instret;
        q.push_back(c);
    endtask

    task automatic add_idle(input int n, input logic run_v);
        for (int i = 0; i < n; i++) add_cyc(3'd0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, run_v);
    endtask

    // One instruction: fw/dw are wait states before the fetch/data ack.
    task automatic add_instr(input logic mem, rd, br, bt, input logic [1:0] wb,
                             input int fw, dw, input logic run_mid, run_wb);
        logic tk;
        cur_mem = mem; cur_rd = rd; cur_br = br; cur_bt = bt; cur_wb = wb;
        tk = br & bt;
        for (int i = 0; i <= fw; i++)
            add_cyc(3'd1, i == fw, 1, 0, 0, i == fw, 0, 0, 0, 0, run_mid);
        add_cyc(3'd2, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, run_mid);  // stray ack must be ignored
        add_cyc(3'd3, 1'b0, 0, 0, 0, 0, tk, tk, 0, 0, run_mid);
        if (!br && mem)
            for (int i = 0; i <= dw; i++)
                add_cyc(3'd4, i == dw, 1, !rd, 1, 0, 0, 0, 0, 0, run_wb);
        add_cyc(3'd5, 1'b0, 0, 0, 0, 0, !tk, 0, wb[1], wb[0], run_wb);
        m_instret = m_instret + 1;
    endtask

    task automatic run_trace();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            run = c.run; dec_mem = c.mem; dec_mem_read = c.rd; dec_branch = c.br;
            branch_taken = c.bt; dec_wb = c.wb; mem_ack = c.ack;
            @(negedge clk);
            n_cyc++;
            chk($sformatf("cycle %0d outputs", n_cyc),
                32'({state_dbg, mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel,
                     rf_we, wb_sel, busy, fault}), 32'(c.exp));
            chk($sformatf("cycle %0d instret", n_cyc), instret, c.exp_instret);
        end
    endtask

    initial begin
        int sz;
        rst_n = 1'b0; run = 1'b0; dec_mem = 1'b0; dec_mem_read = 1'b0; dec_branch = 1'b0;
        branch_taken = 1'b0; dec_wb = 2'b00; mem_ack = 1'b0;
        cur_mem = 0; cur_rd = 0; cur_br = 0; cur_bt = 0; cur_wb = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset state_dbg", 32'(state_dbg), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset instret", instret, 32'd0);
        rst_n = 1'b1;

        add_idle(1, 1'b1);
        sz = q.size();
        add_instr(0, 0, 0, 0, 2'b10, 0, 0, 1, 1);             // ADD, zero wait
        chk("model add length", 32'(q.size() - sz), 32'd4);
        sz = q.size();
        add_instr(1, 1, 0, 0, 2'b11, 0, 3, 1, 1);             // load, 3 data waits
        chk("model load length", 32'(q.size() - sz), 32'd8);
        sz = q.size();
        add_instr(1, 0, 1, 1, 2'b00, 0, 0, 1, 1);             // taken branch with dec_mem set
        chk("model branch length", 32'(q.size() - sz), 32'd4);
        add_instr(1, 0, 1, 0, 2'b10, 2, 0, 1, 1);             // not-taken branch
        add_instr(0, 0, 0, 0, 2'b11, 1, 0, 1, 1);             // ALU after branch
        add_instr(1, 0, 0, 0, 2'b00, 0, 2, 1, 0);             // store, run dropped in MEM
        add_idle(3, 1'b0);
        run_trace();
        chk("instret after six", instret, 32'd6);

        add_idle(1, 1'b1);
        cur_mem = 0; cur_rd = 0; cur_br = 0; cur_bt = 0; cur_wb = 2'b00;
        for (int i = 0; i < 3; i++) add_cyc(3'd1, 1'b0, 1, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        run_trace();
        chk("mid-fetch mem_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset mem_req", 32'(mem_req), 32'd0);
        chk("async reset state_dbg", 32'(state_dbg), 32'd0);
        chk("async reset instret", instret, 32'd0);
        m_instret = 0;
        run = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MEM_TIMEOUT_EN
        add_idle(1, 1'b1);
        add_instr(0, 0, 0, 0, 2'b10, 15, 0, 1, 1);            // ack on the last allowed cycle
        cur_mem = 0; cur_rd = 0; cur_br = 0; cur_bt = 0; cur_wb = 2'b00;
        for (int i = 0; i < 16; i++) add_cyc(3'd1, 1'b0, 1, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        m_fault = 1'b1;
        for (int i = 0; i < 4; i++) add_cyc(3'd6, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        run_trace();
        chk("halt state_dbg", 32'(state_dbg), 32'd6);
        chk("halt fault", 32'(fault), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("fault cleared by reset", 32'(fault), 32'd0);
        chk("halt exit state_dbg", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
